// File: rtl/commit_drop_packet_fifo_pkg.sv
// Shared types and helpers for the commit/drop packet FIFO.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: write-FSM state encoding, pointer-width helper and a
// saturating counter increment used by the drop/overflow statistics.
package commit_drop_packet_fifo_pkg;

    // Write side FSM: words stream in while WRITING, then the block waits
    // for the filter verdict before taking the next packet.
    typedef enum logic [0:0] {
        ST_WRITING       = 1'b0,
        ST_AWAIT_VERDICT = 1'b1
    } wr_state_t;

    // Widest counter the saturation helper supports.
    localparam int CNT_MAX_WIDTH = 64;

    // Pointers carry one extra wrap bit so that full and empty can be told
    // apart when the address bits are equal.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Increment a counter of 'width' bits, sticking at all-ones instead of
    // wrapping. The value is passed zero-extended to CNT_MAX_WIDTH bits.
    function automatic logic [CNT_MAX_WIDTH-1:0] cnt_sat_inc(
        input logic [CNT_MAX_WIDTH-1:0] cnt,
        input int unsigned              width
    );
        logic [CNT_MAX_WIDTH-1:0] max_val;
        if (width >= CNT_MAX_WIDTH) begin
            max_val = '1;
        end else begin
            max_val = (64'd1 << width) - 64'd1;
        end
        if (cnt >= max_val) begin
            return max_val;
        end
        return cnt + 64'd1;
    endfunction

endpackage

// File: rtl/commit_drop_packet_fifo_if.sv
// Bus bundle for the commit/drop packet FIFO (write, verdict, read, stats).
// Latency: n/a (wires only).
// Backpressure: valid/ready on the write, verdict and read channels.
//
// master: packet source, verdict source and reader (snooper/filter/forwarder side)
// slave : the FIFO itself
interface commit_drop_packet_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    // write channel
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_valid;
    logic                  wr_ready;
    // verdict channel
    logic                  verdict_valid;
    logic                  verdict_accept;
    logic                  verdict_ready;
    // read channel
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  rd_valid;
    logic                  rd_ready;
    // statistics / status
    logic [CNT_WIDTH-1:0]  drop_count;
    logic [CNT_WIDTH-1:0]  overflow_count;
    logic                  pkt_pending;

    modport master (
        output wr_data, wr_last, wr_valid,
        input  wr_ready,
        output verdict_valid, verdict_accept,
        input  verdict_ready,
        input  rd_data, rd_last, rd_valid,
        output rd_ready,
        input  drop_count, overflow_count, pkt_pending
    );

    modport slave (
        input  wr_data, wr_last, wr_valid,
        output wr_ready,
        input  verdict_valid, verdict_accept,
        output verdict_ready,
        output rd_data, rd_last, rd_valid,
        input  rd_ready,
        output drop_count, overflow_count, pkt_pending
    );

endinterface

// File: rtl/commit_drop_packet_fifo_sdp_ram.sv
// Inferred simple dual-port RAM: one write port, one registered read port.
// Latency: read data appears one clock after rd_en; it holds while rd_en is low.
// Backpressure: none; the caller guarantees address separation.
//
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_en/rd_addr/rd_data (read).
// The array is deliberately not reset so it maps onto block RAM.
module commit_drop_packet_fifo_sdp_ram #(
    parameter int WIDTH      = 65,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/commit_drop_packet_fifo.sv
// Speculative packet FIFO: words are buffered, then a verdict commits or rewinds the packet.
// Latency: first word on rd_valid two clocks after the committing verdict handshake.
// Backpressure: writer never stalled mid-packet (overflow truncates); verdict and reader are valid/ready.
//
// Ports: clk, rst (async, active low) and one bus interface (slave side) carrying
// the write channel, verdict channel, read channel and drop/overflow statistics.
module commit_drop_packet_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    commit_drop_packet_fifo_if.slave   bus
);

    import commit_drop_packet_fifo_pkg::*;

    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int EW    = DATA_WIDTH + 1;   // entry = {last, data}

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_t              state;
    logic                   truncated;
    logic [PW-1:0]          spec_ptr;
    logic [PW-1:0]          commit_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   wr_ready;
    logic                   verdict_ready;
    logic [CNT_WIDTH-1:0]   drop_count;
    logic [CNT_WIDTH-1:0]   overflow_count;

    logic                   ram_vld;     // RAM output register holds an unconsumed word
    logic [EW-1:0]          ram_q;
    logic                   rd_valid;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_last;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic wr_fire;
    logic vd_fire;
    logic full;
    logic ram_we;

    assign wr_fire = bus.wr_valid & wr_ready;
    assign vd_fire = bus.verdict_valid & verdict_ready;
    // Space is measured against rd_ptr, so committed-but-unread words count
    // as occupied and a new packet truncates until the reader frees space.
    assign full    = (spec_ptr - rd_ptr) == PW'(DEPTH);
    // wr_ready is only high in WRITING, so no state qualifier is needed.
    assign ram_we  = wr_fire & ~full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_WRITING;
            truncated      <= 1'b0;
            spec_ptr       <= '0;
            commit_ptr     <= '0;
            wr_ready       <= 1'b0;
            verdict_ready  <= 1'b0;
            drop_count     <= '0;
            overflow_count <= '0;
        end else begin
            case (state)
                ST_WRITING: begin
                    wr_ready      <= 1'b1;
                    verdict_ready <= 1'b0;
                    if (wr_fire) begin
                        // A word that does not fit is swallowed; the packet
                        // is rewound at verdict time whatever the verdict.
                        if (full) begin
                            truncated <= 1'b1;
                        end else begin
                            spec_ptr <= spec_ptr + PW'(1);
                        end
                        if (bus.wr_last) begin
                            state         <= ST_AWAIT_VERDICT;
                            wr_ready      <= 1'b0;
                            verdict_ready <= 1'b1;
                        end
                    end
                end
                ST_AWAIT_VERDICT: begin
                    wr_ready      <= 1'b0;
                    verdict_ready <= 1'b1;
                    if (vd_fire) begin
                        if (truncated) begin
                            spec_ptr       <= commit_ptr;
                            overflow_count <= CNT_WIDTH'(cnt_sat_inc(
                                                  CNT_MAX_WIDTH'(overflow_count), CNT_WIDTH));
                        end else if (bus.verdict_accept) begin
                            commit_ptr <= spec_ptr;
                        end else begin
                            spec_ptr   <= commit_ptr;
                            drop_count <= CNT_WIDTH'(cnt_sat_inc(
                                              CNT_MAX_WIDTH'(drop_count), CNT_WIDTH));
                        end
                        truncated     <= 1'b0;
                        state         <= ST_WRITING;
                        wr_ready      <= 1'b1;
                        verdict_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_WRITING;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic avail;
    logic out_free;
    logic ram_re;

    commit_drop_packet_fifo_sdp_ram #(
        .WIDTH      (EW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (spec_ptr[ADDR_WIDTH-1:0]),
        .wr_data ({bus.wr_last, bus.wr_data}),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_q)
    );

    // ------------------------------------------------------------------
    // Read side: RAM output stage feeding a one-entry output register.
    // A read is issued when committed data exists and the RAM stage is
    // either empty or draining into the output register this cycle; the
    // RAM output holds its value while no read is issued, so a stalled
    // word is never overwritten.
    // ------------------------------------------------------------------
    assign avail    = commit_ptr != rd_ptr;
    assign out_free = ~rd_valid | bus.rd_ready;
    assign ram_re   = avail & (~ram_vld | out_free);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            ram_vld  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            if (ram_re) begin
                rd_ptr  <= rd_ptr + PW'(1);
                ram_vld <= 1'b1;
            end else if (out_free) begin
                ram_vld <= 1'b0;
            end

            if (ram_vld && out_free) begin
                rd_valid <= 1'b1;
                rd_last  <= ram_q[EW-1];
                rd_data  <= ram_q[DATA_WIDTH-1:0];
            end else if (bus.rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_ready       = wr_ready;
    assign bus.verdict_ready  = verdict_ready;
    assign bus.rd_valid       = rd_valid;
    assign bus.rd_data        = rd_data;
    assign bus.rd_last        = rd_last;
    assign bus.drop_count     = drop_count;
    assign bus.overflow_count = overflow_count;
    // The word in flight in the RAM stage has already advanced rd_ptr but
    // is still unread, so it keeps the pending flag up as well.
    assign bus.pkt_pending    = avail | ram_vld | rd_valid;

endmodule

// File: tb/tb_commit_drop_packet_fifo.sv
// Directed self-checking bench for commit_drop_packet_fifo (8-word depth).
// Latency: n/a.
// Backpressure: reader ready is driven per test, including a fixed toggle pattern.
module tb_commit_drop_packet_fifo;

    logic clk;
    logic rst;

    commit_drop_packet_fifo_if #(.DATA_WIDTH(64), .CNT_WIDTH(32)) bus ();

    commit_drop_packet_fifo #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (3),
        .CNT_WIDTH  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [64:0] got_q[$];   // {last, data} as handed over to the reader
    logic [64:0] exp_q[$];

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reader monitor: collects handshaken words and checks that a stalled
    // word stays valid and unchanged until it is taken.
    logic        hold_vld = 1'b0;
    logic [64:0] hold_val = '0;
    always @(negedge clk) begin
        if (!rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("stall_valid_held", bus.rd_valid, 1'b1);
                chk("stall_word_stable", {bus.rd_last, bus.rd_data}, hold_val);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                got_q.push_back({bus.rd_last, bus.rd_data});
            end
            hold_vld = bus.rd_valid && !bus.rd_ready;
            hold_val = {bus.rd_last, bus.rd_data};
        end
    end

    task automatic send_word(input logic [63:0] d, input logic last);
        int n = 0;
        while (!bus.wr_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_ready_seen", bus.wr_ready, 1'b1);
        bus.wr_data  = d;
        bus.wr_last  = last;
        bus.wr_valid = 1'b1;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    // Returns one time step after the handshake edge.
    task automatic send_verdict(input logic accept);
        int n = 0;
        while (!bus.verdict_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("verdict_ready_seen", bus.verdict_ready, 1'b1);
        bus.verdict_valid  = 1'b1;
        bus.verdict_accept = accept;
        @(posedge clk); #1;
        bus.verdict_valid  = 1'b0;
        bus.verdict_accept = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] base, input int len, input logic accept);
        for (int i = 0; i < len; i++) begin
            send_word(base + 64'(i), i == len - 1);
            if (accept) exp_q.push_back({i == len - 1, base + 64'(i)});
        end
        send_verdict(accept);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_data = '0;
        bus.verdict_valid = 1'b0; bus.verdict_accept = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_ready"},      bus.wr_ready, 1'b0);
        chk({tag, "_verdict_ready"}, bus.verdict_ready, 1'b0);
        chk({tag, "_rd_valid"},      bus.rd_valid, 1'b0);
        chk({tag, "_rd_data"},       bus.rd_data, 64'h0);
        chk({tag, "_rd_last"},       bus.rd_last, 1'b0);
        chk({tag, "_drop"},          bus.drop_count, 32'h0);
        chk({tag, "_ovf"},           bus.overflow_count, 32'h0);
        chk({tag, "_pending"},       bus.pkt_pending, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat;
        int n;

        // ---------------- reset state ----------------
        rst = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_data = '0;
        bus.verdict_valid = 1'b0; bus.verdict_accept = 1'b0;
        bus.rd_ready = 1'b0;
        #13;
        check_idle_outputs("rst");
        @(negedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wr_ready_after", bus.wr_ready, 1'b1);

        // ---------------- accept path with latency ----------------
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(64'hA0 + 64'(i), i == 3);
            exp_q.push_back({i == 3, 64'hA0 + 64'(i)});
        end
        send_verdict(1'b1);                           // edge N
        chk("acc_lat_n0_valid", bus.rd_valid, 1'b0);
        @(posedge clk); #1;                           // edge N+1
        chk("acc_lat_n1_valid", bus.rd_valid, 1'b0);
        @(posedge clk); #1;                           // edge N+2
        chk("acc_lat_n2_valid", bus.rd_valid, 1'b1);
        chk("acc_lat_n2_data",  bus.rd_data, 64'hA0);
        chk("acc_lat_n2_last",  bus.rd_last, 1'b0);
        drain("acc");
        chk("acc_drop", bus.drop_count, 32'd0);
        chk("acc_pending_after", bus.pkt_pending, 1'b0);

        // ---------------- verdict ignored while writing ----------------
        bus.verdict_valid  = 1'b1;
        bus.verdict_accept = 1'b0;
        @(posedge clk); #1;
        chk("vd_ignored_ready", bus.verdict_ready, 1'b0);
        @(posedge clk); #1;
        bus.verdict_valid  = 1'b0;
        chk("vd_ignored_drop", bus.drop_count, 32'd0);

        // ---------------- reject then accept ----------------
        send_pkt(64'hC0, 3, 1'b0);
        @(posedge clk); #1;
        chk("rej_drop", bus.drop_count, 32'd1);
        send_pkt(64'hB0, 2, 1'b1);
        drain("rej");
        chk("rej_drop_final", bus.drop_count, 32'd1);
        chk("rej_ovf", bus.overflow_count, 32'd0);

        // ---------------- overflow truncation ----------------
        do_reset();
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ovf_wr_ready_%0d", i), bus.wr_ready, 1'b1);
            send_word(64'hD0 + 64'(i), i == 9);
        end
        send_verdict(1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("ovf_count", bus.overflow_count, 32'd1);
        chk("ovf_drop", bus.drop_count, 32'd0);
        chk("ovf_rd_valid", bus.rd_valid, 1'b0);
        chk("ovf_pending", bus.pkt_pending, 1'b0);
        bus.rd_ready = 1'b1;
        send_pkt(64'hE0, 2, 1'b1);
        drain("ovf_next");

        // ---------------- wrap-around streaming ----------------
        bus.rd_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            send_pkt(64'h100 + 64'(p * 4), 3, 1'b1);
        end
        drain("wrap");
        chk("wrap_ovf", bus.overflow_count, 32'd1);
        chk("wrap_drop", bus.drop_count, 32'd0);

        // ---------------- reader back-pressure ----------------
        bus.rd_ready = 1'b0;
        send_pkt(64'h200, 6, 1'b1);
        pat = 32'hB53C_96E1;
        for (int i = 0; i < 40; i++) begin
            bus.rd_ready = pat[i % 32];
            @(posedge clk); #1;
        end
        bus.rd_ready = 1'b1;
        drain("bp");

        // ---------------- asynchronous reset mid-operation ----------------
        bus.rd_ready = 1'b0;
        send_pkt(64'hF0, 1, 1'b1);
        n = 0;
        while (!bus.rd_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_rd_valid_before", bus.rd_valid, 1'b1);
        chk("mid_pending_before", bus.pkt_pending, 1'b1);
        send_word(64'h300, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        #3 rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        bus.rd_ready = 1'b1;
        send_pkt(64'h400, 1, 1'b1);
        drain("mid_after");
        chk("mid_after_pending", bus.pkt_pending, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
